solver_control: RTL and testbench
=================================

# solver_control

Sequencing controller for the multi-limb fixed-point escape-time solver. It holds two runtime settings: the operand width in limbs and the iteration limit. On `start` it steps the arithmetic datapath through iterations, and within each iteration it issues one limb index per cycle. It samples the datapath's `diverged` flag after each iteration and reports the iteration count and escape status when finished.

## Interface
Parameters:
- `LIMB_INDEX_BITS`, default 6: width of the limb count and limb index.

Ports:
- `clock`  in  1: single clock; all logic is rising-edge.
- `reset`  in  1: asynchronous, active-low reset.
- `wr_num_limbs_en`  in  1: write strobe for the limb-count register.
- `num_limbs_data`  in  LIMB_INDEX_BITS: new limb count.
- `wr_iter_lim_en`  in  1: write strobe for the iteration-limit register.
- `iter_lim_data`  in  16: new iteration limit.
- `start`  in  1: begin a solve; level sampled in IDLE.
- `diverged`  in  1: datapath escape flag; sampled only in CHECK.
- `busy`  out  1: high in every state except IDLE.
- `load_en`  out  1: datapath initial-load strobe (z ← c).
- `limb_valid`  out  1: a limb index is presented this cycle.
- `limb_idx`  out  LIMB_INDEX_BITS: current limb index.
- `first_limb`, `last_limb`  out  1 each: qualify limb 0 and limb num_limbs_eff−1.
- `check`  out  1: `diverged` is being sampled this cycle.
- `done`  out  1: one-cycle completion pulse.
- `escaped`  out  1: result flag, set when the solve ended by divergence.
- `iterations`  out  16: result count.

## Operation
- Settings registers:
  - Reset values: `num_limbs` = 1, `iter_lim` = 0.
  - Writes take effect only in IDLE. Writes while busy are ignored.
  - A write in the same cycle as `start` is accepted, and the new value governs that solve.
  - num_limbs_eff = max(num_limbs, 1).
- States: IDLE, LOAD, SWEEP, CHECK, DONE.
  - IDLE: on `start` → LOAD.
  - LOAD: `load_en`=1; clear iter_count, `iterations` and `escaped`. If `iter_lim`==0 → DONE; otherwise limb_idx←0 → SWEEP.
  - SWEEP: `limb_valid`=1. limb_idx increments each cycle. On the last limb → CHECK.
  - CHECK:
    - `diverged`=1: `iterations`←iter_count+1, `escaped`←1 → DONE.
    - Else if iter_count+1 == `iter_lim`: `iterations`←`iter_lim`, `escaped`←0 → DONE.
    - Else iter_count++ → SWEEP (limb_idx←0).
  - DONE: `done`=1 → IDLE.
- With num_limbs_eff=1, `first_limb` and `last_limb` are both high in the single SWEEP cycle.
- `start` is ignored while busy. `diverged` is ignored outside CHECK.
- `iterations` and `escaped` hold until the next LOAD.

## Timing
- Reset (asynchronous, active-low): state IDLE. All outputs 0, except `iterations` 0 and settings registers at their reset values. Reset mid-solve aborts with no `done` pulse.
- All outputs are registered or decoded from registered state; there are no combinational input-to-output paths.
- Start latency: `start` sampled at edge k; LOAD occupies cycle k+1.
- Each iteration takes num_limbs_eff+1 cycles: the SWEEP cycles plus one CHECK cycle.
- Solve length, `start` edge to `done` inclusive: 2 + N·(num_limbs_eff+1) cycles, where N is the number of iterations executed.
- `iter_lim`=0 gives 2 cycles: LOAD then DONE.
- `iter_lim`=65535 is legal. iter_count never wraps, because the limit check precedes the increment.

## Configuration
- `SOLVER_CONTROL_ABORT_EN`:
  - Defined: adds input `abort` (1 bit). `abort` high in any non-IDLE state returns to IDLE on the next edge. There is no `done` pulse, and `iterations`/`escaped` are left cleared.
  - Undefined: no port and no logic.

## Structure
- Shared package `solver_pkg`:
  - state enum (IDLE, LOAD, SWEEP, CHECK, DONE);
  - `ITER_BITS` = 16;
  - reset constants for `num_limbs` (1) and `iter_lim` (0).
- One sub-module is natural: `limb_sequencer`. It owns the limb index counter and generates `limb_valid`/`first_limb`/`last_limb` from a clear and an enable. The top level holds the settings registers, the FSM and the iteration counter.

## Test plan
- num_limbs=5, iter_lim=3, `diverged`=0, pulse `start` → 3 sweeps of limb_idx 0..4, `done` in cycle 20 after start, `iterations`=3, `escaped`=0.
- Same settings, `diverged`=1 during the second CHECK → `done` in cycle 14, `iterations`=2, `escaped`=1.
- iter_lim=0, `start` → LOAD then `done` in cycle 2, `iterations`=0, no `limb_valid`.
- num_limbs=0, iter_lim=2 → one-cycle sweeps with `first_limb`=`last_limb`=1, `done` in cycle 6.
- Write num_limbs=7 while busy → ignored; the current and next solves still use 5.
- Drive `reset`=0 during SWEEP → immediate IDLE, `busy`=0, no `done`; a following `start` completes normally.

Source files
------------

// File: rtl/solver_pkg.sv
// Shared definitions for the escape-time solver control slice.
//   state_t          : controller state encoding (IDLE, LOAD, SWEEP, CHECK, DONE)
//   ITER_BITS        : width of the iteration limit / iteration count
//   NUM_LIMBS_RESET  : reset value of the limb-count setting
//   ITER_LIM_RESET   : reset value of the iteration-limit setting
package solver_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SWEEP,
    ST_CHECK,
    ST_DONE
  } state_t;

  localparam int unsigned ITER_BITS       = 16;
  localparam int unsigned NUM_LIMBS_RESET = 1;
  localparam logic [ITER_BITS-1:0] ITER_LIM_RESET = '0;

endpackage

// File: rtl/limb_sequencer.sv
// Limb index generator for one solver iteration.
//   clock, reset   : rising-edge clock, asynchronous active-low reset
//   clear          : force the limb index back to 0
//   enable         : a sweep is in progress; present and advance the index
//   num_limbs_eff  : number of limbs per sweep (always >= 1)
//   limb_valid     : index is presented this cycle
//   limb_idx       : current limb index
//   first_limb     : limb 0 is presented
//   last_limb      : limb num_limbs_eff-1 is presented
module limb_sequencer #(
  parameter int unsigned LIMB_INDEX_BITS = 6
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       enable,
  input  logic [LIMB_INDEX_BITS-1:0] num_limbs_eff,
  output logic                       limb_valid,
  output logic [LIMB_INDEX_BITS-1:0] limb_idx,
  output logic                       first_limb,
  output logic                       last_limb
);

  logic [LIMB_INDEX_BITS-1:0] last_idx;

  assign last_idx   = num_limbs_eff - LIMB_INDEX_BITS'(1);
  assign limb_valid = enable;
  assign first_limb = enable && (limb_idx == '0);
  assign last_limb  = enable && (limb_idx == last_idx);

  // The index wraps to 0 after the last limb so the next sweep starts
  // cleanly even without an explicit clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      limb_idx <= '0;
    end else if (clear) begin
      limb_idx <= '0;
    end else if (enable) begin
      if (limb_idx == last_idx) begin
        limb_idx <= '0;
      end else begin
        limb_idx <= limb_idx + LIMB_INDEX_BITS'(1);
      end
    end
  end

endmodule

// File: rtl/solver_control.sv
// Sequencing controller for the multi-limb fixed-point escape-time solver.
// Holds the limb-count and iteration-limit settings, steps the datapath
// through iterations (one limb index per cycle, then a divergence check)
// and reports the iteration count and escape status.
//   clock, reset            : rising-edge clock, asynchronous active-low reset
//   wr_num_limbs_en/_data   : limb-count write (accepted in IDLE only)
//   wr_iter_lim_en/_data    : iteration-limit write (accepted in IDLE only)
//   start                   : begin a solve (sampled in IDLE)
//   diverged                : datapath escape flag (sampled in CHECK)
//   abort                   : return to IDLE without done (only with
//                             SOLVER_CONTROL_ABORT_EN defined)
//   busy, load_en, limb_valid, limb_idx, first_limb, last_limb, check, done
//                           : sequencing outputs decoded from registered state
//   escaped, iterations     : registered solve result
// Optional feature macro: SOLVER_CONTROL_ABORT_EN
module solver_control
  import solver_pkg::*;
#(
  parameter int unsigned LIMB_INDEX_BITS = 6
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       wr_num_limbs_en,
  input  logic [LIMB_INDEX_BITS-1:0] num_limbs_data,
  input  logic                       wr_iter_lim_en,
  input  logic [ITER_BITS-1:0]       iter_lim_data,
  input  logic                       start,
  input  logic                       diverged,
`ifdef SOLVER_CONTROL_ABORT_EN
  input  logic                       abort,
`endif
  output logic                       busy,
  output logic                       load_en,
  output logic                       limb_valid,
  output logic [LIMB_INDEX_BITS-1:0] limb_idx,
  output logic                       first_limb,
  output logic                       last_limb,
  output logic                       check,
  output logic                       done,
  output logic                       escaped,
  output logic [ITER_BITS-1:0]       iterations
);

  state_t                     state;
  logic [LIMB_INDEX_BITS-1:0] num_limbs;
  logic [LIMB_INDEX_BITS-1:0] num_limbs_eff;
  logic [ITER_BITS-1:0]       iter_lim;
  logic [ITER_BITS-1:0]       iter_count;
  logic [ITER_BITS-1:0]       iter_next;
  logic                       seq_clear;
  logic                       seq_last;
  logic                       abort_req;

`ifdef SOLVER_CONTROL_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign num_limbs_eff = (num_limbs == '0) ? LIMB_INDEX_BITS'(1) : num_limbs;

  // iter_count stays below iter_lim, so the increment cannot wrap.
  assign iter_next = iter_count + ITER_BITS'(1);

  assign busy      = (state != ST_IDLE);
  assign load_en   = (state == ST_LOAD);
  assign check     = (state == ST_CHECK);
  assign done      = (state == ST_DONE);
  assign seq_clear = (state == ST_LOAD) || (state == ST_CHECK);

  limb_sequencer #(
    .LIMB_INDEX_BITS(LIMB_INDEX_BITS)
  ) u_limb_sequencer (
    .clock        (clock),
    .reset        (reset),
    .clear        (seq_clear),
    .enable       (state == ST_SWEEP),
    .num_limbs_eff(num_limbs_eff),
    .limb_valid   (limb_valid),
    .limb_idx     (limb_idx),
    .first_limb   (first_limb),
    .last_limb    (seq_last)
  );

  assign last_limb = seq_last;

  // Results are cleared on the IDLE->LOAD transition so that an abort at
  // any later point still leaves them cleared.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      num_limbs  <= LIMB_INDEX_BITS'(NUM_LIMBS_RESET);
      iter_lim   <= ITER_LIM_RESET;
      iter_count <= '0;
      iterations <= '0;
      escaped    <= 1'b0;
    end else if (abort_req && (state != ST_IDLE)) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (wr_num_limbs_en) num_limbs <= num_limbs_data;
          if (wr_iter_lim_en)  iter_lim  <= iter_lim_data;
          if (start) begin
            state      <= ST_LOAD;
            iter_count <= '0;
            iterations <= '0;
            escaped    <= 1'b0;
          end
        end
        ST_LOAD: begin
          iter_count <= '0;
          state      <= (iter_lim == '0) ? ST_DONE : ST_SWEEP;
        end
        ST_SWEEP: begin
          if (seq_last) state <= ST_CHECK;
        end
        ST_CHECK: begin
          if (diverged) begin
            iterations <= iter_next;
            escaped    <= 1'b1;
            state      <= ST_DONE;
          end else if (iter_next == iter_lim) begin
            iterations <= iter_lim;
            escaped    <= 1'b0;
            state      <= ST_DONE;
          end else begin
            iter_count <= iter_next;
            state      <= ST_SWEEP;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_solver_control.sv
module tb_solver_control;

  localparam int unsigned LB = 6;
  localparam int unsigned VW = 24 + LB;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          wr_num_limbs_en = 1'b0;
  logic [LB-1:0] num_limbs_data = '0;
  logic          wr_iter_lim_en = 1'b0;
  logic [15:0]   iter_lim_data = '0;
  logic          start = 1'b0;
  logic          diverged = 1'b0;
  logic          busy, load_en, limb_valid, first_limb, last_limb, check, done, escaped;
  logic [LB-1:0] limb_idx;
  logic [15:0]   iterations;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Behavioural copy of the settings registers
  int unsigned m_nl  = 1;
  int unsigned m_lim = 0;

  always #5 clock = ~clock;

  solver_control #(.LIMB_INDEX_BITS(LB)) dut (
    .clock          (clock),
    .reset          (reset),
    .wr_num_limbs_en(wr_num_limbs_en),
    .num_limbs_data (num_limbs_data),
    .wr_iter_lim_en (wr_iter_lim_en),
    .iter_lim_data  (iter_lim_data),
    .start          (start),
    .diverged       (diverged),
    .busy           (busy),
    .load_en        (load_en),
    .limb_valid     (limb_valid),
    .limb_idx       (limb_idx),
    .first_limb     (first_limb),
    .last_limb      (last_limb),
    .check          (check),
    .done           (done),
    .escaped        (escaped),
    .iterations     (iterations)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_settings(input int unsigned nl, input int unsigned lim);
    wr_num_limbs_en = 1'b1;
    num_limbs_data  = LB'(nl);
    wr_iter_lim_en  = 1'b1;
    iter_lim_data   = 16'(lim);
    tick();
    wr_num_limbs_en = 1'b0;
    wr_iter_lim_en  = 1'b0;
    m_nl  = nl;
    m_lim = lim;
  endtask

  // One solve. d = iteration whose CHECK sees diverged=1 (0 = never).
  // Expected timeline: cycle 1 LOAD, then N iterations of (leff SWEEP + CHECK),
  // then DONE in cycle 2 + N*(leff+1).
  task automatic run_solve(input string name, input int unsigned d, input bit noise,
                           input bit busy_write, input bit wr_with_start,
                           input int unsigned nl_new, input int unsigned lim_new);
    int unsigned leff, n, total, pos, chk_no;
    bit          esc;
    bit          e_valid, e_check;
    logic [VW-1:0] exp_v, act_v;
    if (wr_with_start) begin
      wr_num_limbs_en = 1'b1;
      num_limbs_data  = LB'(nl_new);
      wr_iter_lim_en  = 1'b1;
      iter_lim_data   = 16'(lim_new);
      m_nl  = nl_new;
      m_lim = lim_new;
    end
    leff = (m_nl == 0) ? 1 : m_nl;
    if (m_lim == 0) begin
      n = 0; esc = 1'b0;
    end else if (d != 0 && d <= m_lim) begin
      n = d; esc = 1'b1;
    end else begin
      n = m_lim; esc = 1'b0;
    end
    total = 2 + n * (leff + 1);
    start = 1'b1;
    diverged = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    tick();
    start = 1'b0;
    wr_num_limbs_en = 1'b0;
    wr_iter_lim_en  = 1'b0;
    for (int unsigned c = 1; c <= total; c++) begin
      e_valid = 1'b0; e_check = 1'b0; pos = 0; chk_no = 0;
      if (c > 1 && c < total) begin
        pos = (c - 2) % (leff + 1);
        if (pos == leff) begin
          e_check = 1'b1;
          chk_no  = (c - 1) / (leff + 1);
        end else begin
          e_valid = 1'b1;
        end
      end
      exp_v = {1'b1, (c == 1), e_valid, e_valid && pos == 0, e_valid && pos == leff - 1,
               e_check, (c == total), (c == total) ? esc : 1'b0,
               (c == total) ? 16'(n) : 16'd0, e_valid ? LB'(pos) : LB'(0)};
      act_v = {busy, load_en, limb_valid, first_limb, last_limb, check, done, escaped,
               iterations, e_valid ? limb_idx : LB'(0)};
      n_tests++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got %h expected %h", name, c, act_v, exp_v);
      end
      if (e_check) diverged = (d != 0 && chk_no == d);
      else         diverged = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (busy_write && c == 3) begin
        wr_num_limbs_en = 1'b1;
        num_limbs_data  = LB'(7);
        wr_iter_lim_en  = 1'b1;
        iter_lim_data   = 16'($urandom_range(1, 9));
      end else begin
        wr_num_limbs_en = 1'b0;
        wr_iter_lim_en  = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    diverged = 1'b0;
    wr_num_limbs_en = 1'b0;
    wr_iter_lim_en  = 1'b0;
    n_tests++;
    if ({busy, done, escaped, iterations} !== {1'b0, 1'b0, esc, 16'(n)}) begin
      n_fail++;
      $display("FAIL %s idle_hold: got busy=%b done=%b esc=%b iter=%0d expected 0 0 %b %0d",
               name, busy, done, escaped, iterations, esc, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1;
    n_tests++;
    if ({busy, load_en, limb_valid, first_limb, last_limb, check, done, escaped, iterations} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b/%b/%b/%b/%b/%b/%b/%b/%0d expected all zero",
               busy, load_en, limb_valid, first_limb, last_limb, check, done, escaped, iterations);
    end
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    m_nl = 1; m_lim = 0;
    tick();
    run_solve("reset_defaults", 0, 1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic test_full_run();
    set_settings(5, 3);
    run_solve("full_run", 0, 1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic test_diverge();
    set_settings(5, 3);
    run_solve("diverge", 2, 1'b1, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic test_zero_limit();
    set_settings(5, 0);
    run_solve("zero_limit", 0, 1'b1, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic test_zero_limbs();
    set_settings(0, 2);
    run_solve("zero_limbs", 0, 1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic test_busy_write();
    set_settings(5, 3);
    run_solve("busy_write", 0, 1'b1, 1'b1, 1'b0, 0, 0);
    run_solve("after_busy_write", 0, 1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic test_write_with_start();
    set_settings(5, 3);
    run_solve("write_with_start", 0, 1'b0, 1'b0, 1'b1, 3, 2);
  endtask

  task automatic test_max_limit();
    set_settings(2, 65535);
    run_solve("max_limit", 4, 1'b1, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic test_midsolve_reset();
    bit bad;
    set_settings(5, 3);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    n_tests++;
    if (limb_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_in_sweep: got limb_valid=%b expected 1", limb_valid);
    end
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if ({busy, limb_valid, done, iterations} !== '0) begin
      n_fail++;
      $display("FAIL midreset_async: got busy=%b valid=%b done=%b iter=%0d expected 0 0 0 0",
               busy, limb_valid, done, iterations);
    end
    m_nl = 1; m_lim = 0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (busy !== 1'b0 || done !== 1'b0) bad = 1'b1;
      tick();
    end
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL midreset_quiet: got activity after reset expected idle with no done");
    end
    set_settings(5, 3);
    run_solve("after_midreset", 0, 1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic test_random();
    int unsigned nl, lim, d;
    for (int i = 0; i < 12; i++) begin
      nl  = $urandom_range(0, 9);
      lim = $urandom_range(0, 5);
      d   = $urandom_range(0, lim + 1);
      if ($urandom_range(0, 1) == 1) begin
        set_settings(nl, lim);
        run_solve("random", d, 1'b1, 1'b0, 1'b0, 0, 0);
      end else begin
        run_solve("random_ws", d, 1'b1, 1'b0, 1'b1, nl, lim);
      end
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_diverge();
    test_zero_limit();
    test_zero_limbs();
    test_busy_write();
    test_write_with_start();
    test_max_limit();
    test_midsolve_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
